// File: rtl/seg_pkg.sv
// Shared glyph constants for the seven-segment decoder.
// Segment vectors are active-low, packed as {g, f, e, d, c, b, a}.
package seg_pkg;

    // Glyph codes beyond the hex range that carry meaning
    localparam logic [4:0] CODE_BLANK = 5'd16;
    localparam logic [4:0] CODE_DASH  = 5'd17;

    // Non-digit glyphs
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Hex digit glyphs (lower-case b and d keep them distinct from 8 and 0)
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

endpackage : seg_pkg

// File: rtl/seg_glyph_lut.sv
// Combinational glyph lookup: 5-bit code to active-low segment pattern.
// Codes 0-15 show hex digits, 17 shows a dash, everything else is blank.
module seg_glyph_lut
    import seg_pkg::*;
(
    input  logic [4:0] bin_in,
    output logic [6:0] seg_out
);

    // Decode the code to its glyph; blank is the fallback for unused codes
    always_comb begin
        // NOTE: assigning a default before the case guarantees seg_out is
        // driven on every path, so no latch can be inferred.
        seg_out = SEG_BLANK;
        case (bin_in)
            5'd0:       seg_out = SEG_0;
            5'd1:       seg_out = SEG_1;
            5'd2:       seg_out = SEG_2;
            5'd3:       seg_out = SEG_3;
            5'd4:       seg_out = SEG_4;
            5'd5:       seg_out = SEG_5;
            5'd6:       seg_out = SEG_6;
            5'd7:       seg_out = SEG_7;
            5'd8:       seg_out = SEG_8;
            5'd9:       seg_out = SEG_9;
            5'd10:      seg_out = SEG_A;
            5'd11:      seg_out = SEG_B;
            5'd12:      seg_out = SEG_C;
            5'd13:      seg_out = SEG_D;
            5'd14:      seg_out = SEG_E;
            5'd15:      seg_out = SEG_F;
            CODE_BLANK: seg_out = SEG_BLANK;
            CODE_DASH:  seg_out = SEG_DASH;
            default:    seg_out = SEG_BLANK;
        endcase
    end

endmodule : seg_glyph_lut

// File: rtl/seg_decode_clk_div.sv
// Programmable clock divider plus seven-segment glyph decoder.
// divided_clk is a registered data signal toggled in the clk domain; it is
// never used as a clock inside this block. The decoder is independent of
// the divider and of reset.
module seg_decode_clk_div
    import seg_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] div_max,
    output logic             divided_clk,
    output logic             div_tick,
    input  logic [4:0]       bin_in,
    output logic [6:0]       seg_out
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dclk_q, dclk_d;
    logic             tick_q, tick_d;
    logic             at_term;

    // Next-state: wrap and toggle once the count reaches or passes div_max.
    // Using >= rather than == lets a lowered div_max take effect on the very
    // next compare instead of letting the counter run around the full range.
    always_comb begin
        at_term = (cnt_q >= div_max);
        cnt_d   = cnt_q + CNT_W'(1);
        dclk_d  = dclk_q;
        tick_d  = 1'b0;
        if (at_term) begin
            cnt_d  = '0;
            dclk_d = ~dclk_q;
            tick_d = 1'b1;
        end
    end

    // Divider state registers; reset wins over a terminal-count toggle
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            cnt_q  <= '0;
            dclk_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dclk_q <= dclk_d;
            tick_q <= tick_d;
        end
    end

    assign divided_clk = dclk_q;
    assign div_tick    = tick_q;

    seg_glyph_lut u_glyph_lut (
        .bin_in  (bin_in),
        .seg_out (seg_out)
    );

endmodule : seg_decode_clk_div

// File: tb/tb_seg_decode_clk_div.sv
// Directed bench for seg_decode_clk_div: divider waveform and glyph table.
// Expectations come from closed-form phase formulas and a literal glyph
// table, pushed to scoreboard queues as stimulus is applied.
module tb_seg_decode_clk_div;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] div_max;
    logic             divided_clk;
    logic             div_tick;
    logic [4:0]       bin_in;
    logic [6:0]       seg_out;

    typedef struct packed {
        logic dclk;
        logic tick;
    } div_exp_t;

    div_exp_t   div_q[$];
    logic [6:0] seg_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    seg_decode_clk_div #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .div_max     (div_max),
        .divided_clk (divided_clk),
        .div_tick    (div_tick),
        .bin_in      (bin_in),
        .seg_out     (seg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference glyph table, written out independently of the design package
    function automatic logic [6:0] glyph_ref(input int code);
        case (code)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            15: return 7'b0001110;
            17: return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock: queue the expected divider outputs, advance, then compare
    task automatic step(input string tag, input logic e_dclk, input logic e_tick);
        div_exp_t e;
        e.dclk = e_dclk;
        e.tick = e_tick;
        div_q.push_back(e);
        @(posedge clk);
        #1;
        e = div_q.pop_front();
        chk({tag, "_dclk"}, {7'd0, divided_clk}, {7'd0, e.dclk});
        chk({tag, "_tick"}, {7'd0, div_tick}, {7'd0, e.tick});
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Apply a code, queue its glyph, let the combinational path settle, compare
    task automatic seg_step(input int code);
        logic [6:0] e;
        bin_in = code[4:0];
        seg_q.push_back(glyph_ref(code));
        #1;
        e = seg_q.pop_front();
        chk($sformatf("seg_%0d", code), {1'b0, seg_out}, {1'b0, e});
    endtask

    initial begin
        rst     = 1'b1;
        div_max = CNT_W'(3);
        bin_in  = 5'd0;

        // Reset held three cycles: all divider outputs low
        for (int i = 0; i < 3; i++) step($sformatf("rst%0d", i), 1'b0, 1'b0);

        // div_max=3: four cycles low, four high, tick on every toggle
        rst = 1'b0;
        for (int n = 1; n <= 24; n++)
            step($sformatf("dm3_n%0d", n), 1'(((n / 4) % 2)), (n % 4) == 0);

        // div_max=0: toggle every cycle, tick stuck high
        rst = 1'b1;
        step("dm0_rst", 1'b0, 1'b0);
        rst     = 1'b0;
        div_max = '0;
        for (int n = 1; n <= 8; n++)
            step($sformatf("dm0_n%0d", n), 1'(n % 2), 1'b1);

        // Large divisor lowered mid-count: wrap next cycle, then 22-cycle period
        rst     = 1'b1;
        div_max = CNT_W'(40000);
        step("big_rst", 1'b0, 1'b0);
        rst = 1'b0;
        run(29999);
        step("big_pre", 1'b0, 1'b0);
        div_max = CNT_W'(10);
        for (int m = 0; m <= 44; m++)
            step($sformatf("dm10_m%0d", m), 1'(((m / 11) % 2) == 0), (m % 11) == 0);

        // div_max=5: reset lands in a high phase on the would-be toggle edge
        rst     = 1'b1;
        div_max = CNT_W'(5);
        step("dm5_rst", 1'b0, 1'b0);
        rst = 1'b0;
        for (int n = 1; n <= 11; n++)
            step($sformatf("dm5_n%0d", n), 1'(((n / 6) % 2)), (n % 6) == 0);
        rst = 1'b1;
        step("dm5_abort", 1'b0, 1'b0);
        step("dm5_hold", 1'b0, 1'b0);
        rst = 1'b0;
        for (int n = 1; n <= 6; n++)
            step($sformatf("dm5_rel%0d", n), n == 6, n == 6);

        // Glyph sweep; upper half with reset asserted to show independence
        for (int c = 0; c < 16; c++) seg_step(c);
        rst = 1'b1;
        for (int c = 16; c < 32; c++) seg_step(c);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seg_decode_clk_div

// File: doc/seg_decode_clk_div.md
SEG_DECODE_CLK_DIV -- requirements
Module: seg_decode_clk_div

Interface
REQ-001 Parameter: CNT_W, default 16, width of divider counter and terminal-count input.
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: div_max  input  CNT_W  divider terminal count, unsigned.
REQ-005 Port: divided_clk  output  1  registered divided clock, 50% duty.
REQ-006 Port: div_tick  output  1  registered one-cycle pulse on each divided_clk toggle.
REQ-007 Port: bin_in  input  5  glyph code to decode.
REQ-008 Port: seg_out  output  7  segment drive, active-low, bit0=a ... bit6=g.

Function
REQ-009 Divider counter SHALL be a CNT_W-bit register that increments by 1 each clk cycle.
REQ-010 When counter >= div_max, counter SHALL load 0, divided_clk SHALL invert and div_tick SHALL be 1 for that cycle only.
REQ-011 divided_clk period SHALL be 2*(div_max+1) clk cycles; high and low phases SHALL each be div_max+1 cycles.
REQ-012 div_max=0 SHALL toggle divided_clk every clk cycle, with div_tick held at 1.
REQ-013 A div_max change mid-count SHALL apply on the next compare; a counter already above the new div_max SHALL wrap on the next cycle, never run to 2^CNT_W.
REQ-014 Counter SHALL never overflow; arithmetic is unsigned, no sign extension.
REQ-015 Decoder SHALL be purely combinational, zero-cycle latency from bin_in to seg_out, and independent of rst and of the divider.
REQ-016 Codes 0-15 SHALL display hex glyphs 0-9, A, b, C, d, E, F.
REQ-017 Required encodings: 0->1000000, 1->1111001, 8->0000000, A(10)->0001000, F(15)->0001110.
REQ-018 Code 16 SHALL be blank (1111111).
REQ-019 Code 17 SHALL be dash (0111111).
REQ-020 Codes 18-31 SHALL be blank (1111111).
REQ-021 seg_out SHALL never be X/Z for any defined bin_in (full case with default).

Reset
REQ-022 On rst=1 at a clk edge: counter=0, divided_clk=0, div_tick=0.
REQ-023 rst asserted mid-period SHALL abort the current phase; counting restarts from 0 on the first edge with rst=0.
REQ-024 rst SHALL take priority over the terminal-count toggle in the same cycle.

Structure
REQ-025 Shared package seg_pkg SHALL hold the glyph constants (SEG_BLANK, SEG_DASH, hex digit patterns) and the code values 16/17.
REQ-026 Decoder SHALL be one sub-module, seg_glyph_lut (bin_in -> seg_out), instantiated once.
REQ-027 Divider logic SHALL reside in the top module; no derived clock SHALL be used internally to clock any logic.

Verification
REQ-028 rst high 3 cycles, then div_max=3 -> divided_clk 0 for 4 cycles, 1 for 4 cycles, repeating; div_tick pulses every 4 cycles.
REQ-029 div_max=0 -> divided_clk toggles every cycle; div_tick constant 1 after reset release.
REQ-030 div_max=40000 running with counter ~30000, then div_max changed to 10 -> toggle within 1 cycle; period thereafter 22 cycles.
REQ-031 Sweep bin_in 0..31 -> seg_out matches the REQ-016..020 table, including 0->1000000, 15->0001110, 16->1111111, 17->0111111, 31->1111111.
REQ-032 Assert rst during a high phase with div_max=5 -> divided_clk=0 next edge; first toggle 6 cycles after release.
